// File: rtl/mult_div_unit.sv
// mult_div_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Executes mult/multu/div/divu over a fixed number of Busy cycles and
// mthi/mtlo in a single cycle.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu.
//
// Handshake: Start is a one-cycle qualifier for MDOp, accepted only while
// Busy=0. Busy rises the cycle after acceptance and stays high for exactly
// MULT_CYCLES or DIV_CYCLES cycles; HI/LO update on the edge where Busy
// falls. Requests seen while Busy=1 are dropped without side effects.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] In0,
  input  logic [31:0] In1,
  input  logic [3:0]  MDOp,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        o_dbg_state,
  output logic [3:0]  o_dbg_count
);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic        r_busy;

  logic        w_is_mul;
  logic        w_is_div;
  logic        w_accept;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_acc;
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_bs_div;
  logic [31:0] w_bu_div;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  logic [31:0] w_q_s;
  logic [31:0] w_r_s;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [63:0] w_res;
  logic        w_wr;

  assign Busy        = r_busy;
  assign HI          = r_hi;
  assign LO          = r_lo;
  assign o_dbg_state = r_state;
  assign o_dbg_count = r_cnt;

  // Classify the incoming op as a legal multi-cycle start.
  always_comb begin
    w_is_mul = (MDOp == OP_MULT) || (MDOp == OP_MULTU);
    w_is_div = (MDOp == OP_DIV) || (MDOp == OP_DIVU);
`ifdef MDU_MADD_EN
    if ((MDOp == OP_MADD) || (MDOp == OP_MADDU) ||
        (MDOp == OP_MSUB) || (MDOp == OP_MSUBU)) begin
      w_is_mul = 1'b1;
    end
`endif
  end

  assign w_accept = Start && (w_is_mul || w_is_div);

  // Products from the latched operands, sign- or zero-extended to 64 bits.
  assign w_prod_s = 64'($signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b}));
  assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};
  assign w_acc    = {r_hi, r_lo};

  // Signed divide via magnitudes so 0x80000000 / -1 wraps cleanly; a zero
  // divisor is replaced by 1 only to keep the datapath X-free (not written).
  assign w_a_neg  = r_a[31];
  assign w_b_neg  = r_b[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - r_a) : r_a;
  assign w_b_mag  = w_b_neg ? (32'd0 - r_b) : r_b;
  assign w_bs_div = (r_b == 32'd0) ? 32'd1 : w_b_mag;
  assign w_bu_div = (r_b == 32'd0) ? 32'd1 : r_b;
  assign w_q_mag  = w_a_mag / w_bs_div;
  assign w_r_mag  = w_a_mag % w_bs_div;
  assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_r_s    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
  assign w_q_u    = r_a / w_bu_div;
  assign w_r_u    = r_a % w_bu_div;

  // Select the {HI,LO} value to commit at completion of the latched op.
  always_comb begin
    w_res = w_acc;
    w_wr  = 1'b1;
    case (r_op)
      OP_MULT:  w_res = w_prod_s;
      OP_MULTU: w_res = w_prod_u;
      OP_DIV: begin
        w_res = {w_r_s, w_q_s};
        w_wr  = (r_b != 32'd0);
      end
      OP_DIVU: begin
        w_res = {w_r_u, w_q_u};
        w_wr  = (r_b != 32'd0);
      end
`ifdef MDU_MADD_EN
      OP_MADD:  w_res = w_acc + w_prod_s;
      OP_MADDU: w_res = w_acc + w_prod_u;
      OP_MSUB:  w_res = w_acc - w_prod_s;
      OP_MSUBU: w_res = w_acc - w_prod_u;
`endif
      default:  w_wr  = 1'b0;
    endcase
  end

  // Control FSM: accept/latch in IDLE, count down in BUSY, commit at the end.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 4'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_op    <= 4'd0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state <= S_BUSY;
            r_busy  <= 1'b1;
            r_cnt   <= w_is_div ? DIV_N : MULT_N;
            r_a     <= In0;
            r_b     <= In1;
            r_op    <= MDOp;
          end else if (MDOp == OP_MTHI) begin
            r_hi <= In0;
          end else if (MDOp == OP_MTLO) begin
            r_lo <= In0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            if (w_wr) begin
              r_hi <= w_res[63:32];
              r_lo <= w_res[31:0];
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers. It sits in the E stage beside the single-cycle arithmetic unit and executes mult/multu/div/divu/mthi/mtlo.
- It exposes Busy so hazard logic stalls any HI/LO-dependent instruction in D while an operation is in flight.
- HI/LO reads (mfhi/mflo) are combinational off the HI and LO outputs.

Parameters:
- MULT_CYCLES, 5, number of Busy cycles for mult/multu (and madd family when enabled); legal range 1..15.
- DIV_CYCLES, 10, number of Busy cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- In0  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- In1  input  32  rt operand (divisor / multiplier)
- MDOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, others none
- Start  input  1  qualifies MDOp for ops 1-4 and 7-10; one-cycle pulse
- Busy  output  1  operation in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset: synchronous, checked at posedge clk before any other action.
  - Sets HI=0, LO=0, Busy=0, state IDLE, counter 0, latched operands 0.
  - Reset asserted mid-operation aborts the operation; HI/LO still become 0 and the result is never written.
- States: IDLE, BUSY; internal 4-bit down-counter.
- IDLE, Start=1, MDOp in {1,2,3,4}:
  - Latch In0, In1 and the op at the edge.
  - Go to BUSY with counter = MULT_CYCLES or DIV_CYCLES.
  - If Start is accepted in cycle t, Busy=1 for cycles t+1 .. t+N.
- BUSY: counter decrements each edge. On the edge that ends cycle t+N:
  - write HI/LO;
  - return to IDLE;
  - Busy=0 from cycle t+N+1.
- Busy is a registered output and is never high in the Start cycle itself. The pipeline must treat Start OR Busy as "MDU occupied"; this unit does not generate that OR.
- mthi/mtlo (5/6): single cycle, need no Start, only in IDLE. HI (or LO) <= In0 at the edge; Busy stays 0.
- Arithmetic, results from the latched operands:
  - mult: signed 32x32 -> 64, {HI,LO}=product.
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - divu: unsigned quotient/remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (latched In1 == 0): runs the full DIV_CYCLES with Busy; HI/LO left unchanged at completion.
- Start or mthi/mtlo while Busy=1: ignored entirely. Operands are not re-latched and HI/LO are not touched. The hazard unit guarantees this does not occur; the bench checks the unit is robust to it.
- Start with MDOp outside the legal start ops: ignored.
- HI/LO outputs change only at completion, on mthi/mtlo, or on reset. Intermediate values are never visible.
- Undefined MDOp codes: no effect.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined:
  - Ops 7-10 are legal with Start and take MULT_CYCLES.
  - madd: {HI,LO} <= {HI,LO} + signed(In0*In1).
  - maddu: {HI,LO} <= {HI,LO} + unsigned(In0*In1).
  - msub/msubu: same as madd/maddu but subtracting.
  - 64-bit wrap-around, no overflow flag.
  - The accumulator source is the HI/LO value at completion time.
- Undefined: codes 7-10 behave as none (no Busy, no HI/LO change).

Test Plan:
- Reset, then mult In0=0xFFFFFFFE (-2), In1=3 with Start at cycle 0:
  - Busy=1 cycles 1-5, 0 at cycle 6;
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu In0=0xFFFFFFFF, In1=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001 after 5 Busy cycles.
- div In0=-7 (0xFFFFFFF9), In1=2 -> Busy 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu In0=7, In1=2 -> LO=3, HI=1.
- divu with In1=0 -> 10 Busy cycles; HI/LO unchanged.
- mthi In0=0x12345678, next cycle mtlo In0=0x9ABCDEF0:
  - HI/LO updated one edge each; Busy stays 0.
- Then mult 2x3, with mthi 0xDEAD issued during Busy -> mthi is ignored; HI=0, LO=6.
- Reset asserted at Busy cycle 3 of a div -> next cycle Busy=0, HI=LO=0; no later write-back.
- With MDU_MADD_EN, HI=0, LO=0xFFFFFFFF, maddu 1x1 -> HI=1, LO=0.
